adc_uart_tx: RTL and testbench
==============================

ADC_UART_TX -- requirements
Module: adc_uart_tx

Interface
REQ-001 Parameter CLKS_PER_BIT, default 434, clk cycles per UART bit (50 MHz / 115200 baud); legal range 2..65535.
REQ-002 Parameter FIFO_DEPTH, default 4, sample buffer entries; power of two, 2..16.
REQ-003 clk  input  1  system clock; all logic on its rising edge.
REQ-004 reset  input  1  synchronous, active-high reset.
REQ-005 sample  input  12  ADC sample to transmit.
REQ-006 sample_valid  input  1  sample presented this cycle.
REQ-007 sample_ready  output  1  high when FIFO not full; a sample is accepted on a cycle with sample_valid && sample_ready.
REQ-008 UART_TX  output  1  serial line, 8N1, LSB first, idle high.
REQ-009 busy  output  1  high while a frame is on the line or the FIFO is non-empty.
REQ-010 overflow  output  1  sticky; set when sample_valid is high while sample_ready is low.

Function
REQ-011 Each accepted sample SHALL be sent as two UART frames: byte A = {4'hA, sample[11:8]}, then byte B = sample[7:0].
REQ-012 Frame = 1 start bit (0), 8 data bits LSB first, 1 stop bit (1); each bit held exactly CLKS_PER_BIT cycles.
REQ-013 Byte B's start bit SHALL immediately follow byte A's stop bit; no idle gap.
REQ-014 Samples SHALL be sent in acceptance order; the FIFO holds FIFO_DEPTH samples.
REQ-015 Transmit FSM states: IDLE, START, DATA, STOP; a byte-select flag selects byte A or byte B.
REQ-016 IDLE: UART_TX = 1. When the FIFO is non-empty, pop one sample into the shift register, clear the byte-select flag, and go to START on the next cycle.
REQ-017 START: UART_TX = 0 for CLKS_PER_BIT cycles, then go to DATA with bit index 0.
REQ-018 DATA: UART_TX = data[bit index]. After CLKS_PER_BIT cycles, increment the index; after index 7, go to STOP.
REQ-019 STOP: UART_TX = 1 for CLKS_PER_BIT cycles.
REQ-020 Leaving STOP after byte A: set the byte-select flag and go to START.
REQ-021 Leaving STOP after byte B: if the FIFO is non-empty, pop and go to START with no idle cycle; otherwise go to IDLE.
REQ-022 Minimum sample period on the line: 20*CLKS_PER_BIT cycles.
REQ-023 Latency: the first start bit begins 2 cycles after acceptance into an empty, idle block. Cycle 1 is the write; cycle 2 is the pop to START.
REQ-024 UART_TX SHALL be registered, with no combinational path from any input.
REQ-025 Simultaneous push and pop on a full FIFO: the pop frees the entry, but sample_ready is evaluated from the pre-pop count, so the push is refused and overflow is set.
REQ-026 Simultaneous push and pop with 1 entry: the count stays 1 and data order is preserved.
REQ-027 FIFO read and write pointers wrap modulo FIFO_DEPTH; the count SHALL be one bit wider than the pointers.
REQ-028 A refused sample is discarded, not queued.
REQ-029 The baud counter is free of drift: it reloads to 0 on every bit boundary and counts 0..CLKS_PER_BIT-1.

Reset
REQ-030 While reset is high, the following SHALL be forced: UART_TX = 1, FSM = IDLE, FIFO empty (pointers and count 0), sample_ready = 1, busy = 0, overflow = 0, baud counter 0, bit index 0.
REQ-031 Reset asserted mid-frame SHALL abort the frame at the next clk edge: UART_TX returns high and queued samples are lost.
REQ-032 overflow clears only on reset.

Verification (CLKS_PER_BIT=4, FIFO_DEPTH=4)
REQ-033 Single sample 12'h5C3 into idle block.
- Start bit 2 cycles after acceptance.
- Line shows byte 8'hA5 then 8'hC3, back to back, 80 cycles total.
- busy falls the cycle UART_TX completes the final stop bit.
REQ-034 Burst of 5 samples (12'h001..12'h005) on consecutive cycles.
- First 4 plus 1 more accepted: the pop at cycle 2 frees one entry.
- All 5 transmitted in order with no idle between frames.
- overflow stays 0.
REQ-035 Burst of 7 samples with no gaps.
- sample_ready drops after 5 accepted.
- Samples 6 and 7 refused; overflow = 1 and stays 1.
- Exactly 5 samples appear on the line.
REQ-036 Reset mid-frame.
- Assert reset during DATA bit 3 of byte A of 12'hFFF.
- Next cycle: UART_TX = 1, busy = 0, sample_ready = 1.
- After release, the line stays idle high until a new sample is given.
REQ-037 Edge-aligned bit timing: a UART receiver model sampling at mid-bit decodes the exact byte sequence over 100 random samples, with every bit width exactly 4 cycles.

Source files
------------

// File: rtl/adc_uart_tx.sv
// adc_uart_tx: buffers 12-bit ADC samples in a FIFO and sends each one as
// two back-to-back 8N1 UART bytes, {4'hA, sample[11:8]} then sample[7:0].
module adc_uart_tx #(
  parameter int CLKS_PER_BIT = 434,
  parameter int FIFO_DEPTH = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [11:0] sample,
  input  logic        sample_valid,
  output logic        sample_ready,
  output logic        UART_TX,
  output logic        busy,
  output logic        overflow
);
  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int CW = $clog2(CLKS_PER_BIT);
  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;
  state_t state_q, state_d;
  logic [11:0] mem_q [FIFO_DEPTH];
  logic [PW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [PW:0] count_q, count_d;
  logic [CW-1:0] baud_q, baud_d;
  logic [2:0] bit_q, bit_d, bit_nx;
  logic [11:0] shift_q, shift_d;
  logic byte_b_q, byte_b_d, tx_q, tx_d, ovf_q, ovf_d;
  logic full, nonempty, push, pop, baud_end;
  logic [7:0] cur_byte;
  assign full = count_q == (PW+1)'(FIFO_DEPTH);
  assign nonempty = count_q != '0;
  assign push = sample_valid && !full;
  assign baud_end = baud_q == CW'(CLKS_PER_BIT - 1);
  assign cur_byte = byte_b_q ? shift_q[7:0] : {4'hA, shift_q[11:8]};
  assign bit_nx = bit_q + 3'd1;
  // a pop only happens between samples: from IDLE, or at the end of byte B
  assign pop = nonempty && (state_q == IDLE || (state_q == STOP && baud_end && byte_b_q));
  assign sample_ready = reset || !full;
  assign busy = !reset && (state_q != IDLE || nonempty);
  assign overflow = !reset && ovf_q;
  assign UART_TX = tx_q;
  always_comb begin
    wr_ptr_d = wr_ptr_q + PW'(push);
    rd_ptr_d = rd_ptr_q + PW'(pop);
    count_d = count_q + (PW+1)'(push) - (PW+1)'(pop);
    ovf_d = ovf_q || (sample_valid && full);
  end
  always_comb begin
    state_d = state_q;
    baud_d = baud_end ? '0 : baud_q + CW'(1);
    bit_d = bit_q;
    byte_b_d = byte_b_q;
    shift_d = pop ? mem_q[rd_ptr_q] : shift_q;
    tx_d = tx_q;
    case (state_q)
      IDLE: begin
        baud_d = '0;
        state_d = nonempty ? START : IDLE;
        byte_b_d = nonempty ? 1'b0 : byte_b_q;
        tx_d = !nonempty;
      end
      START: if (baud_end) begin
        state_d = DATA;
        bit_d = 3'd0;
        tx_d = cur_byte[0];
      end
      DATA: if (baud_end) begin
        state_d = bit_q == 3'd7 ? STOP : DATA;
        bit_d = bit_q == 3'd7 ? bit_q : bit_nx;
        tx_d = bit_q == 3'd7 ? 1'b1 : cur_byte[bit_nx];
      end
      default: if (baud_end) begin
        state_d = (!byte_b_q || nonempty) ? START : IDLE;
        byte_b_d = !byte_b_q;
        tx_d = byte_b_q && !nonempty;
      end
    endcase
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q <= '0;
      baud_q <= '0;
      bit_q <= '0;
      byte_b_q <= 1'b0;
      shift_q <= '0;
      tx_q <= 1'b1;
      ovf_q <= 1'b0;
    end else begin
      state_q <= state_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q <= count_d;
      baud_q <= baud_d;
      bit_q <= bit_d;
      byte_b_q <= byte_b_d;
      shift_q <= shift_d;
      tx_q <= tx_d;
      ovf_q <= ovf_d;
    end
  end
  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= sample;
  end
endmodule

// File: tb/tb_adc_uart_tx.sv
// tb_adc_uart_tx: cycle-level behavioural model of the sample-to-UART line
// plus directed and random scenarios with a mid-bit UART decoder.
module tb_adc_uart_tx;
  localparam int N = 4;
  localparam int D = 4;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic [11:0] sample = '0;
  logic sample_valid = 1'b0;
  logic sample_ready, UART_TX, busy, overflow;
  int vecs = 0;
  int errs = 0;
  bit chk_en = 1'b0;
  logic [11:0] mq[$];
  logic [11:0] acc_q[$];
  logic [11:0] cur = '0;
  bit act = 1'b0;
  int pos = 0;
  int m_n;
  bit movf = 1'b0;
  logic w [1000];
  logic bz [1000];

  adc_uart_tx #(.CLKS_PER_BIT(N), .FIFO_DEPTH(D)) dut (
    .clk(clk), .reset(rst), .sample(sample), .sample_valid(sample_valid),
    .sample_ready(sample_ready), .UART_TX(UART_TX), .busy(busy), .overflow(overflow)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] a, input logic [31:0] e);
    vecs++;
    if (a !== e) begin
      errs++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, a, e, $time);
    end
  endtask

  // line level at cycle p of a sample's 20-bit transmission window
  function automatic logic fbit(input logic [11:0] s, input int p);
    int b = p / N;
    int k = b % 10;
    logic [7:0] by = (b < 10) ? {4'hA, s[11:8]} : s[7:0];
    return k == 0 ? 1'b0 : k == 9 ? 1'b1 : by[k-1];
  endfunction

  function automatic logic [7:0] dec(input int st);
    logic [7:0] r;
    for (int i = 0; i < 8; i++) r[i] = w[st + (i + 1) * N + N / 2];
    return r;
  endfunction

  always @(posedge clk) begin
    if (rst) begin
      mq.delete();
      act = 1'b0;
      pos = 0;
      movf = 1'b0;
    end else begin
      m_n = mq.size();
      if (sample_valid && m_n >= D) movf = 1'b1;
      if (!act) begin
        if (m_n > 0) begin cur = mq.pop_front(); act = 1'b1; pos = 0; end
      end else if (pos == 20 * N - 1) begin
        if (m_n > 0) begin cur = mq.pop_front(); pos = 0; end
        else act = 1'b0;
      end else pos++;
      if (sample_valid && m_n < D) mq.push_back(sample);
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      chk("tx", UART_TX, act ? fbit(cur, pos) : 1'b1);
      chk("ready", sample_ready, rst || mq.size() < D);
      chk("busy", busy, !rst && (act || mq.size() > 0));
      chk("overflow", overflow, !rst && movf);
    end
  end

  task automatic capture(input int n);
    for (int j = 0; j < n; j++) begin
      @(negedge clk);
      w[j] = UART_TX;
      bz[j] = busy;
    end
  endtask

  function automatic int first_low(input int n);
    for (int j = 0; j < n; j++) if (w[j] === 1'b0) return j;
    return -1;
  endfunction

  task automatic wait_idle();
    int t = 0;
    while (busy !== 1'b0 && t < 2000) begin @(negedge clk); t++; end
    chk("idle_wait", busy, 1'b0);
    @(posedge clk); #1;
  endtask

  task automatic rx_byte(output logic [7:0] b, output bit ok);
    int t = 0;
    ok = 1'b1;
    b = '0;
    @(negedge clk);
    while (UART_TX !== 1'b0 && t < 400) begin @(negedge clk); t++; end
    if (t >= 400) begin ok = 1'b0; return; end
    repeat (N / 2) @(negedge clk);
    if (UART_TX !== 1'b0) ok = 1'b0;
    for (int i = 0; i < 8; i++) begin
      repeat (N) @(negedge clk);
      b[i] = UART_TX;
    end
    repeat (N) @(negedge clk);
    if (UART_TX !== 1'b1) ok = 1'b0;
  endtask

  initial begin
    int lo, bf;
    bit ok;
    repeat (3) @(posedge clk);
    #1 chk_en = 1'b1;
    rst = 1'b0;
    @(negedge clk);
    chk("rst_ready", sample_ready, 1'b1);
    chk("rst_busy", busy, 1'b0);
    chk("rst_tx", UART_TX, 1'b1);
    chk("rst_ovf", overflow, 1'b0);
    @(posedge clk); #1;
    // single sample
    fork
      capture(200);
      begin sample = 12'h5C3; sample_valid = 1'b1; @(posedge clk); #1 sample_valid = 1'b0; end
    join
    lo = first_low(200);
    chk("single_latency", lo, 2);
    chk("single_byteA", dec(lo), 8'hA5);
    chk("single_byteB", dec(lo + 10 * N), 8'hC3);
    bf = -1;
    for (int j = 199; j > lo; j--) if (bz[j] === 1'b0) bf = j;
    chk("single_busy_len", bf - lo, 80);
    chk("single_last_stop", w[lo + 79], 1'b1);
    wait_idle();
    // burst of 5
    fork
      capture(460);
      begin
        for (int i = 0; i < 5; i++) begin
          sample = 12'(i + 1); sample_valid = 1'b1;
          chk("b5_ready", sample_ready, 1'b1);
          @(posedge clk); #1;
        end
        sample_valid = 1'b0;
      end
    join
    lo = first_low(460);
    chk("b5_latency", lo, 2);
    for (int k = 0; k < 5; k++) begin
      chk("b5_byteA", dec(lo + 80 * k), 8'hA0);
      chk("b5_byteB", dec(lo + 80 * k + 40), 32'(k + 1));
    end
    chk("b5_ovf", overflow, 1'b0);
    wait_idle();
    // burst of 7, last two refused
    fork
      capture(480);
      begin
        for (int i = 0; i < 7; i++) begin
          sample = 12'h7E0 + 12'(i + 1); sample_valid = 1'b1;
          chk("b7_ready", sample_ready, i < 5);
          @(posedge clk); #1;
        end
        sample_valid = 1'b0;
      end
    join
    lo = first_low(480);
    for (int k = 0; k < 5; k++) begin
      chk("b7_byteA", dec(lo + 80 * k), 8'hA7);
      chk("b7_byteB", dec(lo + 80 * k + 40), 32'(8'hE1 + k));
    end
    ok = 1'b1;
    for (int j = lo + 400; j < 480; j++) if (w[j] !== 1'b1) ok = 1'b0;
    chk("b7_tail_idle", ok, 1'b1);
    chk("b7_ovf", overflow, 1'b1);
    wait_idle();
    repeat (20) @(posedge clk);
    #1 chk("b7_ovf_sticky", overflow, 1'b1);
    // reset mid-frame
    rst = 1'b1;
    @(posedge clk); #1 rst = 1'b0;
    chk("rst_clears_ovf", overflow, 1'b0);
    sample = 12'hFFF; sample_valid = 1'b1;
    @(posedge clk); #1 sample_valid = 1'b0;
    repeat (17) @(posedge clk);
    #1 chk("mid_frame_active", busy, 1'b1);
    rst = 1'b1;
    @(negedge clk);
    @(negedge clk);
    chk("abort_tx", UART_TX, 1'b1);
    chk("abort_busy", busy, 1'b0);
    chk("abort_ready", sample_ready, 1'b1);
    @(posedge clk); #1 rst = 1'b0;
    ok = 1'b1;
    repeat (100) begin @(negedge clk); if (UART_TX !== 1'b1 || busy !== 1'b0) ok = 1'b0; end
    chk("abort_stays_idle", ok, 1'b1);
    @(posedge clk); #1;
    // random traffic decoded at mid-bit
    fork
      for (int i = 0; i < 100; i++) begin
        int gap, t;
        gap = ($urandom_range(0, 9) == 0) ? $urandom_range(20, 100) : $urandom_range(0, 3);
        repeat (gap) begin @(posedge clk); #1; end
        t = 0;
        while (!sample_ready && t < 2000) begin @(posedge clk); #1; t++; end
        sample = 12'($urandom);
        sample_valid = 1'b1;
        acc_q.push_back(sample);
        @(posedge clk); #1 sample_valid = 1'b0;
      end
      for (int i = 0; i < 100; i++) begin
        logic [7:0] a, b;
        logic [11:0] s;
        bit oa, ob;
        rx_byte(a, oa);
        rx_byte(b, ob);
        chk("rx_frame_ok", oa && ob, 1'b1);
        if (acc_q.size() == 0) chk("rx_unexpected", 1'b1, 1'b0);
        else begin
          s = acc_q.pop_front();
          chk("rx_byteA", a, {4'hA, s[11:8]});
          chk("rx_byteB", b, s[7:0]);
        end
        if (!(oa && ob)) break;
      end
    join
    wait_idle();
    chk("rand_no_ovf", overflow, 1'b0);
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end
endmodule
